fetch_pc_unit: RTL

//  Instruction-fetch front end, directly upstream of the instruction-memory reader.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_skid_buf.sv | 47 ++++
 rtl/fetch_pc_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch buffer entry type for the fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {pc,instr} pairs between the imem response and decode.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   occ,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC, 1-cycle imem request tracking, skid buffer and redirect handling.
// Optional misaligned-redirect trap enabled by `define FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [PC_W-1:0]    id_pc_o,
  output logic               fault_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] issue_pc_q;
  logic            inflight_q;
  logic [1:0]      occ;
  logic [2:0]      pending;
  logic            pop;
  logic            push;
  logic            issue;
  logic            misalign;
  logic            fault;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  assign misalign = |redirect_pc_i[1:0];
  assign fault    = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_i && misalign) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
  assign fault    = 1'b0;
`endif

  assign fault_o = fault;

  // Occupancy counts the response already in flight, so a full buffer never overflows.
  assign pop     = id_valid_o & id_ready_i;
  assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = !fault && !redirect_i && (pending < 3'd2);

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q[IMEM_AW+1:2];

  assign push            = inflight_q & !redirect_i;
  assign push_data.pc    = issue_pc_q;
  assign push_data.instr = imem_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_i) begin
      if (!misalign) begin
        pc_q <= redirect_pc_i & ~32'h3;
      end
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q       <= pc_q + 32'd4;
      issue_pc_q <= pc_q;
      inflight_q <= 1'b1;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fetch_skid_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_i),
    .occ       (occ),
    .head      (head)
  );

  assign id_valid_o = (occ != 2'd0);
  assign id_instr_o = head.instr;
  assign id_pc_o    = head.pc;

endmodule
